// File: rtl/llc_req_driver_pkg.sv
// Shared types for the LLC request driver: FSM state encoding and the
// command record carried through the command queue.
package llc_req_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } llc_drv_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  data;
  } llc_cmd_t;

endpackage

// File: rtl/llc_req_driver_if.sv
// Command/response handshake bundle between a requester (CPU stub, trace
// player) and the LLC request driver.
//   cmd_*  : valid/ready command channel, requester -> driver
//   rsp_*  : valid/ready response channel, driver -> requester
// Modports: slave = driver side, master = requester side.
interface llc_req_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic        rsp_hit;
  logic [7:0]  rsp_data;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_wr, rsp_hit, rsp_data
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_hit, rsp_data
  );
endinterface

// File: rtl/llc_req_driver_cmd_fifo.sv
// Synchronous FIFO of llc_cmd_t records.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (show-ahead head),
// full, empty. Push while full and pop while empty are ignored.
module llc_cmd_fifo
  import llc_req_driver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  llc_cmd_t din,
  input  logic     pop,
  output llc_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  llc_cmd_t          mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr];

  // Storage has no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/llc_req_driver.sv
// Processor-side requester for the LLC. Queues byte read/write commands,
// issues them one at a time on the LLC's unhandshaked port, samples hit/data
// after LLC_LATENCY cycles and returns a response on a valid/ready channel.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : cmd_* command channel in, rsp_* response channel out
//   llc_addr/wr/data_in -> LLC request; llc_hit/llc_data_out <- LLC result
//   busy              : queue non-empty or a command in flight
//   stats_clear       : zero all statistics counters (wins over increments)
//   stat_*            : saturating read/write/hit/miss counters
module llc_req_driver
  import llc_req_driver_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int LLC_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  llc_req_driver_if.slave   bus,
  output logic [31:0]       llc_addr,
  output logic              llc_wr,
  output logic [7:0]        llc_data_in,
  input  logic              llc_hit,
  input  logic [7:0]        llc_data_out,
  output logic              busy,
  input  logic              stats_clear,
  output logic [CNT_W-1:0]  stat_reads,
  output logic [CNT_W-1:0]  stat_writes,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses
);
  localparam int WCW = $clog2(LLC_LATENCY + 1);

  llc_drv_state_e   state, state_d;
  llc_cmd_t         work;
  llc_cmd_t         fifo_head;
  logic             fifo_full, fifo_empty;
  logic             push, pop, sample;
  logic             ready_q;
  logic [WCW-1:0]   wait_cnt;
  logic             rsp_wr_q, rsp_hit_q;
  logic [7:0]       rsp_data_q;
  llc_cmd_t         cmd_in;

  // ready_q keeps cmd_ready low while reset is held without a reset->output path.
  assign bus.cmd_ready = ready_q & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign cmd_in        = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data};

  llc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address/data simply follow the working register, so they hold through
  // WAIT and keep their last value afterwards. Write strobe only in ISSUE.
  assign llc_addr    = work.addr;
  assign llc_data_in = work.data;
  assign llc_wr      = (state == ISSUE) & work.wr;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_data  = rsp_data_q;

  assign busy = (state != IDLE) | ~fifo_empty;

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wait_cnt == WCW'(1)) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      work       <= '0;
      wait_cnt   <= '0;
      rsp_wr_q   <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state   <= state_d;
      ready_q <= 1'b1;
      if (pop) work <= fifo_head;
      if (state == ISSUE)     wait_cnt <= WCW'(LLC_LATENCY);
      else if (state == WAIT) wait_cnt <= wait_cnt - 1'b1;
      if (sample) begin
        rsp_wr_q   <= work.wr;
        rsp_hit_q  <= llc_hit;
        rsp_data_q <= (!work.wr && llc_hit) ? llc_data_out : 8'h00;
      end
    end
  end

  // Statistics: one increment per sampled command, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (sample) begin
      if (!work.wr && !(&stat_reads))  stat_reads  <= stat_reads  + 1'b1;
      if (work.wr  && !(&stat_writes)) stat_writes <= stat_writes + 1'b1;
      if (llc_hit  && !(&stat_hits))   stat_hits   <= stat_hits   + 1'b1;
      if (!llc_hit && !(&stat_misses)) stat_misses <= stat_misses + 1'b1;
    end
  end
endmodule

// File: tb/tb_llc_req_driver.sv
module tb_llc_req_driver;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       llc_addr;
  logic              llc_wr;
  logic [7:0]        llc_data_in;
  logic              llc_hit;
  logic [7:0]        llc_data_out;
  logic              busy;
  logic              stats_clear;
  logic [CNT_W-1:0]  stat_reads, stat_writes, stat_hits, stat_misses;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  llc_req_driver_if bus();

  llc_req_driver #(.FIFO_DEPTH(4), .LLC_LATENCY(1), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .llc_addr     (llc_addr),
    .llc_wr       (llc_wr),
    .llc_data_in  (llc_data_in),
    .llc_hit      (llc_hit),
    .llc_data_out (llc_data_out),
    .busy         (busy),
    .stats_clear  (stats_clear),
    .stat_reads   (stat_reads),
    .stat_writes  (stat_writes),
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses)
  );

  always #5 clk = ~clk;

  // LLC model: one valid line, tag 0x0000123x, byte i = 0x30+i except byte 4 = 0x3C.
  // Result of the address sampled on an edge is visible the following cycle.
  logic [7:0] line [16];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) line[i] <= (i == 4) ? 8'h3C : 8'(8'h30 + i);
      loaded <= 1'b1;
    end else begin
      llc_hit      <= (llc_addr[31:4] == 28'h0000123);
      llc_data_out <= (llc_addr[31:4] == 28'h0000123) ? line[llc_addr[3:0]] : 8'h77;
      if (llc_wr && llc_addr[31:4] == 28'h0000123) line[llc_addr[3:0]] <= llc_data_in;
    end
  end

  always @(posedge clk) if (llc_wr === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.cmd_valid = 1'b0;
    stats_clear   = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] d);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin tick; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout addr=%h", a);
    end
    bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_data = d;
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for a response, records it and completes the handshake (rsp_ready
  // must already be 1).
  task automatic wait_rsp(output logic w, output logic h, output logic [7:0] d);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin tick; n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL rsp_timeout");
    end
    w = bus.rsp_wr; h = bus.rsp_hit; d = bus.rsp_data;
    tick;
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; stats_clear = 1'b0;
    reset = 1'b1;
    tick; tick;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, busy, llc_wr, llc_addr, stat_reads, stat_hits} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rv=%b busy=%b wr=%b addr=%h rd=%0d hit=%0d exp all 0",
               bus.cmd_ready, bus.rsp_valid, busy, llc_wr, llc_addr, stat_reads, stat_hits);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", bus.cmd_ready); end
  endtask

  task automatic test_read_hit;
    do_reset;
    bus.rsp_ready = 1'b1;
    send_cmd(1'b0, 32'h0000_1234, 8'h00);
    tick; // ISSUE
    checks++;
    if (llc_addr !== 32'h0000_1234 || llc_wr !== 1'b0) begin
      errors++; $display("FAIL issue_read addr=%h wr=%b exp 00001234 0", llc_addr, llc_wr);
    end
    tick; // WAIT
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL early_rsp got %b exp 0", bus.rsp_valid); end
    tick; // RESP
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_data !== 8'h3C || bus.rsp_wr !== 1'b0) begin
      errors++; $display("FAIL read_hit_rsp v=%b h=%b d=%h w=%b exp 1 1 3c 0",
                         bus.rsp_valid, bus.rsp_hit, bus.rsp_data, bus.rsp_wr);
    end
    checks++;
    if (stat_reads !== 4'd1 || stat_hits !== 4'd1 || stat_writes !== 4'd0 || stat_misses !== 4'd0) begin
      errors++; $display("FAIL read_hit_stats r=%0d h=%0d w=%0d m=%0d exp 1 1 0 0",
                         stat_reads, stat_hits, stat_writes, stat_misses);
    end
    tick;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_handshake v=%b busy=%b exp 0 0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_write_read;
    logic w, h; logic [7:0] d; int wr0;
    do_reset;
    bus.rsp_ready = 1'b1;
    wr0 = wr_cnt;
    send_cmd(1'b1, 32'h0000_1234, 8'hA5);
    send_cmd(1'b0, 32'h0000_1234, 8'h00);
    wait_rsp(w, h, d);
    checks++;
    if (w !== 1'b1 || h !== 1'b1 || d !== 8'h00) begin
      errors++; $display("FAIL write_rsp w=%b h=%b d=%h exp 1 1 00", w, h, d);
    end
    wait_rsp(w, h, d);
    checks++;
    if (w !== 1'b0 || h !== 1'b1 || d !== 8'hA5) begin
      errors++; $display("FAIL readback_rsp w=%b h=%b d=%h exp 0 1 a5", w, h, d);
    end
    checks++;
    if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL llc_wr_cycles got %0d exp 1", wr_cnt - wr0); end
    checks++;
    if (stat_writes !== 4'd1 || stat_reads !== 4'd1) begin
      errors++; $display("FAIL wr_rd_stats w=%0d r=%0d exp 1 1", stat_writes, stat_reads);
    end
  endtask

  task automatic test_miss;
    logic w, h; logic [7:0] d;
    do_reset;
    bus.rsp_ready = 1'b1;
    send_cmd(1'b0, 32'hDEAD_0000, 8'h00);
    wait_rsp(w, h, d);
    checks++;
    if (h !== 1'b0 || d !== 8'h00) begin errors++; $display("FAIL miss_rsp h=%b d=%h exp 0 00", h, d); end
    checks++;
    if (stat_misses !== 4'd1 || stat_hits !== 4'd0) begin
      errors++; $display("FAIL miss_stats m=%0d h=%0d exp 1 0", stat_misses, stat_hits);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a  [5] = '{32'h0000_1230, 32'h0000_1231, 32'hDEAD_0000, 32'h0000_1232, 32'h0000_1232};
    logic        wv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  dv [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
    logic        eh [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ed [5] = '{8'h30, 8'h31, 8'h00, 8'h00, 8'h11};
    logic w, h; logic [7:0] d, d0;
    int acc = 0;
    do_reset;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cmd_ready === 1'b1) acc++;
      bus.cmd_valid = 1'b1; bus.cmd_wr = wv[i]; bus.cmd_addr = a[i]; bus.cmd_data = dv[i];
      tick;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (acc !== 5 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept accepted=%0d ready=%b exp 5 0", acc, bus.cmd_ready);
    end
    for (int n = 0; n < 20 && bus.rsp_valid !== 1'b1; n++) tick;
    d0 = bus.rsp_data;
    tick; tick; tick;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || d0 !== 8'h30) begin
      errors++; $display("FAIL rsp_hold v=%b d=%h first=%h exp 1 30 30", bus.rsp_valid, bus.rsp_data, d0);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(w, h, d);
      checks++;
      if (w !== wv[i] || h !== eh[i] || d !== ed[i]) begin
        errors++; $display("FAIL b2b_rsp%0d w=%b h=%b d=%h exp %b %b %h", i, w, h, d, wv[i], eh[i], ed[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || stat_reads !== 4'd4 || stat_writes !== 4'd1 || stat_hits !== 4'd4 || stat_misses !== 4'd1) begin
      errors++; $display("FAIL b2b_stats busy=%b r=%0d w=%0d h=%0d m=%0d exp 0 4 1 4 1",
                         busy, stat_reads, stat_writes, stat_hits, stat_misses);
    end
  endtask

  task automatic test_reset_in_wait;
    logic w, h; logic [7:0] d;
    int seen = 0;
    do_reset;
    bus.rsp_ready = 1'b1;
    send_cmd(1'b0, 32'h0000_1234, 8'h00);
    tick; tick; // ISSUE, then WAIT
    reset = 1'b1;
    tick;
    checks++;
    if ({bus.rsp_valid, busy, llc_wr, llc_addr, bus.cmd_ready, stat_reads, stat_hits, stat_misses} !== '0) begin
      errors++; $display("FAIL reset_in_wait v=%b busy=%b addr=%h ready=%b r=%0d h=%0d exp all 0",
                         bus.rsp_valid, busy, llc_addr, bus.cmd_ready, stat_reads, stat_hits);
    end
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin tick; if (bus.rsp_valid === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL dropped_rsp got %0d responses exp 0", seen); end
    send_cmd(1'b0, 32'h0000_1231, 8'h00);
    wait_rsp(w, h, d);
    checks++;
    if (h !== 1'b1 || d !== 8'h31 || stat_reads !== 4'd1) begin
      errors++; $display("FAIL post_reset_cmd h=%b d=%h r=%0d exp 1 31 1", h, d, stat_reads);
    end
  endtask

  task automatic test_saturate_clear;
    logic w, h; logic [7:0] d;
    do_reset;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin send_cmd(1'b0, 32'h0000_1230, 8'h00); wait_rsp(w, h, d); end
    checks++;
    if (stat_hits !== 4'd14) begin errors++; $display("FAIL hits_14 got %0d exp 14", stat_hits); end
    for (int i = 0; i < 2; i++) begin send_cmd(1'b0, 32'h0000_1230, 8'h00); wait_rsp(w, h, d); end
    checks++;
    if (stat_hits !== 4'd15 || stat_reads !== 4'd15 || stat_misses !== 4'd0) begin
      errors++; $display("FAIL saturate h=%0d r=%0d m=%0d exp 15 15 0", stat_hits, stat_reads, stat_misses);
    end
    send_cmd(1'b0, 32'h0000_1230, 8'h00);
    tick; tick;          // ISSUE, WAIT (sample edge ends this cycle)
    stats_clear = 1'b1;
    tick;
    stats_clear = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || {stat_reads, stat_writes, stat_hits, stat_misses} !== '0) begin
      errors++; $display("FAIL clear_vs_sample v=%b r=%0d h=%0d exp 1 0 0", bus.rsp_valid, stat_reads, stat_hits);
    end
    tick;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0; stats_clear = 1'b0;
    tick; tick;
    test_reset;
    test_read_hit;
    test_write_read;
    test_miss;
    test_back_to_back;
    test_reset_in_wait;
    test_saturate_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/llc_req_driver.md
Name: llc_req_driver

Overview:
Processor-side requester for the LLC. It accepts byte read/write commands through a valid/ready queue and issues them one at a time on the LLC's unhandshaked port (addr/wr/data_in -> hit/data_out). It samples the response after a fixed latency, returns the result on a valid/ready response port, and keeps saturating hit/miss/read/write statistics. It sits between the trace/CPU stub and the LLC instance in the cache testbench and integration top.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
LLC_LATENCY, 1, cycles from the LLC sampling a request to data_out/hit being valid (>=1)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command queue can accept (= !full)
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  32  byte address
cmd_data  in  8  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_wr  out  1  op of the completed command
rsp_hit  out  1  LLC hit flag sampled for the command
rsp_data  out  8  read data on read hit; 0 on miss or write
llc_addr  out  32  to LLC addr
llc_wr  out  1  to LLC wr
llc_data_in  out  8  to LLC data_in
llc_hit  in  1  from LLC hit
llc_data_out  in  8  from LLC data_out
busy  out  1  queue non-empty or FSM not IDLE
stats_clear  in  1  zero all counters
stat_reads, stat_writes, stat_hits, stat_misses  out  CNT_W each  saturating counters

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge): FIFO emptied, FSM -> IDLE, all outputs 0 (cmd_ready 0 while reset is asserted, 1 on the first cycle after), counters 0. An in-flight request is dropped and produces no response.
- Queue: push on cmd_valid & cmd_ready. cmd_ready depends only on full, so there is no push-through-when-full even if a pop occurs in the same cycle. Pop and push in the same cycle are legal when not full or empty. Pointers wrap modulo FIFO_DEPTH.
- IDLE: if queue non-empty, pop the head into the working register and go to ISSUE next cycle.
- ISSUE (exactly 1 cycle): llc_addr = cmd_addr, llc_data_in = cmd_data, llc_wr = cmd_wr. Load the wait counter with LLC_LATENCY, then go to WAIT.
- WAIT: llc_addr and llc_data_in held stable. llc_wr forced to 0 so the LLC does not repeat the write. The counter decrements each cycle. On the cycle it reads 1, register rsp_hit = llc_hit, rsp_data = (!wr & llc_hit) ? llc_data_out : 0, rsp_wr = wr, then go to RESP.
- With LLC_LATENCY = 1: ISSUE in cycle t, sample at the end of t+1, rsp_valid high in t+2.
- RESP: rsp_valid = 1 and rsp_* are held until rsp_ready. On the handshake edge go to IDLE, with rsp_valid 0 next cycle. Outside RESP, llc_wr = 0; llc_addr keeps its last value.
- Throughput: one command per LLC_LATENCY+3 cycles when rsp_ready is held high.
- Statistics update on the sample edge:
  - reads or writes +1, according to op;
  - hits or misses +1, according to llc_hit;
  - each counter saturates at all-ones.
- stats_clear wins over a coincident increment: the result is 0.
- busy = (state != IDLE) | !empty.

Decomposition:
- Add to package LLC_defs:
  - typedef enum {IDLE, ISSUE, WAIT, RESP} llc_drv_state_e;
  - typedef struct packed {wr, addr[31:0], data[7:0]} llc_cmd_t.
- Sub-module llc_cmd_fifo: parameterised synchronous FIFO of llc_cmd_t, with push/pop/full/empty and synchronous reset.
- The top holds the FSM, the wait counter and the statistics counters.

Test Plan:
- Bench LLC model: LATENCY 1, line for tag of 0x0000_1230 preloaded valid with byte 4 = 0x3C. Read 0x0000_1234 -> rsp_valid 2 cycles after ISSUE, rsp_hit=1, rsp_data=0x3C, stat_reads=1, stat_hits=1.
- Write 0x0000_1234 data 0xA5, then read same address -> first rsp_wr=1, rsp_hit=1, rsp_data=0. Second rsp_data=0xA5. llc_wr high for exactly one cycle in total.
- Read unmapped 0xDEAD_0000 -> rsp_hit=0, rsp_data=0, stat_misses=1.
- Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after 4 queued entries plus 1 popped. rsp_valid is held with stable data. Releasing rsp_ready drains all 5 in order.
- Assert reset during WAIT -> next cycle all outputs 0, no response appears, counters 0, and a new command afterwards completes normally.
- Force stat_hits to all-ones-1, then issue 2 hits -> saturates at all-ones. stats_clear in the same cycle as a sample -> counters read 0.
